multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Next-generation control for the RISC-V core: a multi-cycle FSM replaces the single-cycle combinational opcode decoder.
- Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, stalls on a memory ready handshake, and traps illegal opcodes.
- Counts retired instructions.
- Sits between the instruction register and the shared-memory multi-cycle datapath; its alu_op feeds the existing ALU control block.

Parameters:
- ALU_OP_W, 2, alu_op width; values 00=add, 01=sub, 10=R-type funct decode, remaining encodings unused; must be >=2.
- CNT_W, 32, width of the retired-instruction counter.
- EN_ALU_I, 1, 1 = opcode 0010011 legal; 0 = it traps.
- EN_JUMP, 1, 1 = opcode 1101111 legal; 0 = it traps.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- opcode  in  7  IR[6:0]; valid from DECODE onward
- mem_ready  in  1  memory completed current request this cycle
- pc_write  out  1  unconditional PC update
- pc_write_cond  out  1  PC update if ALU zero (beq)
- jump  out  1  PC source = jump target
- ir_write  out  1  load IR from memory read data
- i_or_d  out  1  memory address: 0 = PC, 1 = ALU result register
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_2_reg  out  1  register write data from memory data register
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = rs1
- alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate
- alu_op  out  ALU_OP_W  ALU operation class
- illegal  out  1  sticky trap flag
- state  out  3  current state, for debug/verification
- retired  out  CNT_W  instructions completed since reset

Behaviour:
- Encodings:
  - Opcodes: R=0110011, I=0010011, BEQ=1100011, JAL=1101111, LW=0000011, SW=0100011.
  - States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6–7 go to FETCH on the next edge.
- Reset:
  - On an rst edge: state=FETCH, illegal=0, retired=0.
  - While rst=1, all control outputs read 0 combinationally; state and retired read their reset values after the edge.
  - Reset mid-instruction abandons it and does not count it.
- Outputs are combinational from state, opcode and mem_ready. Any output not listed for a state is 0. alu_op defaults to 00.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01.
  - Holds while mem_ready=0.
  - When mem_ready=1, same cycle: ir_write=1, pc_write=1 (PC+4). Next state DECODE.
- DECODE: one cycle. alu_src_a=0, alu_src_b=10 (precompute branch target). Legal opcode -> EXEC; otherwise -> TRAP.
- EXEC, one cycle, by opcode:
  - R: alu_src_a=1, alu_src_b=00, alu_op=10 -> WB.
  - I: alu_src_a=1, alu_src_b=10, alu_op=00 -> WB.
  - LW/SW: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM.
  - BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1 -> FETCH, retire.
  - JAL: pc_write=1, jump=1, alu_op=00 -> FETCH, retire. No link write in this generation.
- MEM:
  - i_or_d=1, with mem_read=1 for LW or mem_write=1 for SW; held stable while mem_ready=0.
  - On mem_ready=1: LW -> WB; SW -> FETCH and retire.
- WB: reg_write=1, mem_2_reg=1 for LW, 0 for R/I. -> FETCH, retire.
- TRAP: illegal=1, all other control outputs 0; absorbing until rst. retired does not increment.
- retired:
  - Increments by 1 on every transition into FETCH that is labelled "retire" above.
  - Wraps from 2^CNT_W-1 to 0.
- Latency in cycles, with zero memory wait:
  - BEQ/JAL = 3
  - R/I/SW = 4
  - LW = 5
  - Each extra wait cycle adds 1 per memory access.
- mem_ready is ignored outside FETCH and MEM.
- opcode changes outside DECODE/EXEC/MEM/WB have no effect.

Test Plan:
- Reset then R-type, mem_ready tied 1 -> state sequence 0,1,2,4,0. reg_write=1 only in WB. retired=1 after 4 cycles.
- LW with mem_ready low for 3 cycles in MEM -> mem_read=1 and i_or_d=1 held all 4 MEM cycles. WB has mem_2_reg=1. Total 8 cycles. retired +1.
- BEQ then SW back-to-back, mem_ready=1 -> BEQ: pc_write_cond=1 in EXEC, alu_op=01, 3 cycles. SW: mem_write=1 in MEM, 4 cycles. retired=2.
- Opcode 1111111 -> DECODE->TRAP. illegal=1 and all control outputs 0 for 10 cycles. retired unchanged. rst -> FETCH, illegal=0.
- EN_JUMP=0, opcode 1101111 -> trap. EN_JUMP=1 -> pc_write=1 and jump=1 in EXEC, then FETCH.
- CNT_W=4: 16 R-type instructions -> retired wraps to 0. rst asserted in MEM of an SW -> mem_write drops the same cycle, state=0 after the edge, no retire.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the RISC-V core: sequences FETCH/DECODE/EXEC/MEM/WB,
// stalls on the memory ready handshake, traps illegal opcodes and counts retired instructions.
module multicycle_control_unit #(
    parameter int unsigned ALU_OP_W = 2,
    parameter int unsigned CNT_W    = 32,
    parameter bit          EN_ALU_I = 1'b1,
    parameter bit          EN_JUMP  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                jump,
    output logic                ir_write,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_2_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal,
    output logic [2:0]          state,
    output logic [CNT_W-1:0]    retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_FUNCT = ALU_OP_W'(2);

    state_t state_q;
    state_t state_n;
    logic   retire;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_BEQ, OP_LW, OP_SW: is_legal = 1'b1;
            OP_I:                       is_legal = EN_ALU_I;
            OP_JAL:                     is_legal = EN_JUMP;
            default:                    is_legal = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            retired <= '0;
        end else begin
            state_q <= state_n;
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_n       = state_q;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        jump          = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_2_reg     = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = ALU_ADD;
        illegal       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_n  = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALU precomputes PC + imm so a taken branch has its target ready in EXEC
                alu_src_b = 2'b10;
                state_n   = is_legal(opcode) ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                case (opcode)
                    OP_R: begin
                        alu_src_a = 1'b1;
                        alu_op    = ALU_FUNCT;
                        state_n   = S_WB;
                    end
                    OP_I: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        state_n   = EN_ALU_I ? S_WB : S_TRAP;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        state_n   = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_src_a     = 1'b1;
                        alu_op        = ALU_SUB;
                        pc_write_cond = 1'b1;
                        state_n       = S_FETCH;
                        retire        = 1'b1;
                    end
                    OP_JAL: begin
                        if (EN_JUMP) begin
                            pc_write = 1'b1;
                            jump     = 1'b1;
                            state_n  = S_FETCH;
                            retire   = 1'b1;
                        end else begin
                            state_n = S_TRAP;
                        end
                    end
                    default: state_n = S_TRAP;
                endcase
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = (opcode == OP_LW);
                mem_write = (opcode == OP_SW);
                if (mem_ready) begin
                    if (opcode == OP_LW) begin
                        state_n = S_WB;
                    end else begin
                        state_n = S_FETCH;
                        retire  = 1'b1;
                    end
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                mem_2_reg = (opcode == OP_LW);
                state_n   = S_FETCH;
                retire    = 1'b1;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: state_n = S_FETCH;
        endcase

        // Reset silences every control line at once so an abandoned access never completes
        if (rst) begin
            retire        = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            jump          = 1'b0;
            ir_write      = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            mem_2_reg     = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = ALU_ADD;
            illegal       = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: default instance plus a CNT_W=4, EN_JUMP=0 instance on shared inputs.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_ready = 1'b0;
    logic [6:0] opcode = 7'd0;

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic        pcw_a, pcc_a, jmp_a, irw_a, iod_a, mr_a, mw_a, m2r_a, rw_a, sa_a, ill_a;
    logic [1:0]  sb_a, aop_a;
    logic [2:0]  state_a;
    logic [31:0] ret_a;

    logic        pcw_b, pcc_b, jmp_b, irw_b, iod_b, mr_b, mw_b, m2r_b, rw_b, sa_b, ill_b;
    logic [1:0]  sb_b, aop_b;
    logic [2:0]  state_b;
    logic [3:0]  ret_b;

    multicycle_control_unit dut_a (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pcw_a), .pc_write_cond(pcc_a), .jump(jmp_a), .ir_write(irw_a),
        .i_or_d(iod_a), .mem_read(mr_a), .mem_write(mw_a), .mem_2_reg(m2r_a),
        .reg_write(rw_a), .alu_src_a(sa_a), .alu_src_b(sb_a), .alu_op(aop_a),
        .illegal(ill_a), .state(state_a), .retired(ret_a)
    );

    multicycle_control_unit #(.CNT_W(4), .EN_JUMP(1'b0)) dut_b (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pcw_b), .pc_write_cond(pcc_b), .jump(jmp_b), .ir_write(irw_b),
        .i_or_d(iod_b), .mem_read(mr_b), .mem_write(mw_b), .mem_2_reg(m2r_b),
        .reg_write(rw_b), .alu_src_a(sa_b), .alu_src_b(sb_b), .alu_op(aop_b),
        .illegal(ill_b), .state(state_b), .retired(ret_b)
    );

    logic [14:0] ctl_a;
    assign ctl_a = {pcw_a, pcc_a, jmp_a, irw_a, iod_a, mr_a, mw_a, m2r_a, rw_a, sa_a, sb_a, aop_a, ill_a};

    function automatic logic [14:0] mk(input logic pcw, pcc, jmp, irw, iod, mr, mw, m2r, rw, sa,
                                       input logic [1:0] sb, input logic [1:0] aop, input logic ill);
        return {pcw, pcc, jmp, irw, iod, mr, mw, m2r, rw, sa, sb, aop, ill};
    endfunction

    logic [14:0] ZERO, F_W, F_R, DEC, EX_R, EX_I, EX_B, EX_J, MEM_LW, MEM_SW, WB_LW, WB_R, TRP;

    logic [17:0] exp_q[$];
    string       tag_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, compare mid-cycle, then cross the edge.
    task automatic step(input string tag, input logic [6:0] op, input logic rdy, input logic r,
                        input logic [14:0] ectl, input logic [2:0] est);
        logic [17:0] e;
        string       t;
        opcode    = op;
        mem_ready = rdy;
        rst       = r;
        exp_q.push_back({est, ectl});
        tag_q.push_back(tag);
        #4;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, "_ctl"}, 32'(ctl_a), 32'(e[14:0]));
        check({t, "_state"}, 32'(state_a), 32'(e[17:15]));
        @(posedge clk);
        #1;
    endtask

    initial begin
        ZERO   = '0;
        F_W    = mk(0,0,0,0,0,1,0,0,0,0,2'b01,2'b00,0);
        F_R    = mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,0);
        DEC    = mk(0,0,0,0,0,0,0,0,0,0,2'b10,2'b00,0);
        EX_R   = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,0);
        EX_I   = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,0);
        EX_B   = mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,0);
        EX_J   = mk(1,0,1,0,0,0,0,0,0,0,2'b00,2'b00,0);
        MEM_LW = mk(0,0,0,0,1,1,0,0,0,0,2'b00,2'b00,0);
        MEM_SW = mk(0,0,0,0,1,0,1,0,0,0,2'b00,2'b00,0);
        WB_LW  = mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,0);
        WB_R   = mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,0);
        TRP    = mk(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,1);

        @(posedge clk);
        #1;
        step("rst", OP_R, 1'b1, 1'b1, ZERO, 3'd0);
        check("rst_ret_a", ret_a, 32'd0);
        check("rst_ret_b", 32'(ret_b), 32'd0);

        // R-type, zero wait
        step("r_fetch", OP_R, 1'b1, 1'b0, F_R, 3'd0);
        step("r_dec",   OP_R, 1'b1, 1'b0, DEC, 3'd1);
        step("r_exec",  OP_R, 1'b1, 1'b0, EX_R, 3'd2);
        step("r_wb",    OP_R, 1'b1, 1'b0, WB_R, 3'd4);
        check("r_ret", ret_a, 32'd1);

        // LW with three wait cycles in MEM
        step("lw_fetch", OP_LW, 1'b1, 1'b0, F_R, 3'd0);
        step("lw_dec",   OP_LW, 1'b1, 1'b0, DEC, 3'd1);
        step("lw_exec",  OP_LW, 1'b1, 1'b0, EX_I, 3'd2);
        for (int i = 0; i < 3; i++) step("lw_mem_wait", OP_LW, 1'b0, 1'b0, MEM_LW, 3'd3);
        step("lw_mem",   OP_LW, 1'b1, 1'b0, MEM_LW, 3'd3);
        step("lw_wb",    OP_LW, 1'b1, 1'b0, WB_LW, 3'd4);
        check("lw_ret", ret_a, 32'd2);

        // BEQ then SW back to back
        step("beq_fetch", OP_BEQ, 1'b1, 1'b0, F_R, 3'd0);
        step("beq_dec",   OP_BEQ, 1'b1, 1'b0, DEC, 3'd1);
        step("beq_exec",  OP_BEQ, 1'b1, 1'b0, EX_B, 3'd2);
        check("beq_ret", ret_a, 32'd3);
        step("sw_fetch", OP_SW, 1'b1, 1'b0, F_R, 3'd0);
        step("sw_dec",   OP_SW, 1'b1, 1'b0, DEC, 3'd1);
        step("sw_exec",  OP_SW, 1'b1, 1'b0, EX_I, 3'd2);
        step("sw_mem",   OP_SW, 1'b1, 1'b0, MEM_SW, 3'd3);
        check("sw_ret", ret_a, 32'd4);

        // I-type: fetch stalls with junk opcode; mem_ready low outside FETCH/MEM is ignored
        step("i_fetch_wait", OP_BAD, 1'b0, 1'b0, F_W, 3'd0);
        step("i_fetch_wait", OP_JAL, 1'b0, 1'b0, F_W, 3'd0);
        step("i_fetch", OP_I, 1'b1, 1'b0, F_R, 3'd0);
        step("i_dec",   OP_I, 1'b0, 1'b0, DEC, 3'd1);
        step("i_exec",  OP_I, 1'b0, 1'b0, EX_I, 3'd2);
        step("i_wb",    OP_I, 1'b0, 1'b0, WB_R, 3'd4);
        check("i_ret", ret_a, 32'd5);

        // Counter wrap on the 4-bit instance
        step("wrap_rst", OP_R, 1'b1, 1'b1, ZERO, 3'd0);
        for (int i = 0; i < 16; i++) begin
            step("wr_fetch", OP_R, 1'b1, 1'b0, F_R, 3'd0);
            step("wr_dec",   OP_R, 1'b1, 1'b0, DEC, 3'd1);
            step("wr_exec",  OP_R, 1'b1, 1'b0, EX_R, 3'd2);
            step("wr_wb",    OP_R, 1'b1, 1'b0, WB_R, 3'd4);
            if (i == 14) check("wrap_ret_b_15", 32'(ret_b), 32'd15);
        end
        check("wrap_ret_b", 32'(ret_b), 32'd0);
        check("wrap_ret_a", ret_a, 32'd16);

        // JAL: legal on dut_a, traps on dut_b
        step("jal_fetch", OP_JAL, 1'b1, 1'b0, F_R, 3'd0);
        step("jal_dec",   OP_JAL, 1'b1, 1'b0, DEC, 3'd1);
        check("jal_b_state", 32'(state_b), 32'd5);
        step("jal_exec",  OP_JAL, 1'b1, 1'b0, EX_J, 3'd2);
        check("jal_ret", ret_a, 32'd17);
        check("jal_b_ill", 32'(ill_b), 32'd1);
        check("jal_b_ret", 32'(ret_b), 32'd0);

        // Illegal opcode traps and stays trapped until reset
        step("bad_fetch", OP_BAD, 1'b1, 1'b0, F_R, 3'd0);
        step("bad_dec",   OP_BAD, 1'b1, 1'b0, DEC, 3'd1);
        for (int i = 0; i < 10; i++) step("trap", (i % 2 == 0) ? OP_R : OP_BAD, 1'b1, 1'b0, TRP, 3'd5);
        check("trap_ret", ret_a, 32'd17);
        check("trap_b_state", 32'(state_b), 32'd5);
        step("trap_rst", OP_BAD, 1'b1, 1'b1, ZERO, 3'd5);
        check("trap_rst_ill", 32'(ill_a), 32'd0);
        check("trap_rst_ret", ret_a, 32'd0);
        check("trap_rst_b_state", 32'(state_b), 32'd0);

        // Recovered instance runs an R, then reset abandons an SW in MEM
        step("r2_fetch", OP_R, 1'b1, 1'b0, F_R, 3'd0);
        step("r2_dec",   OP_R, 1'b1, 1'b0, DEC, 3'd1);
        step("r2_exec",  OP_R, 1'b1, 1'b0, EX_R, 3'd2);
        step("r2_wb",    OP_R, 1'b1, 1'b0, WB_R, 3'd4);
        check("r2_ret", ret_a, 32'd1);
        check("r2_ret_b", 32'(ret_b), 32'd1);
        step("sw2_fetch", OP_SW, 1'b1, 1'b0, F_R, 3'd0);
        step("sw2_dec",   OP_SW, 1'b1, 1'b0, DEC, 3'd1);
        step("sw2_exec",  OP_SW, 1'b1, 1'b0, EX_I, 3'd2);
        step("sw2_mem",   OP_SW, 1'b0, 1'b0, MEM_SW, 3'd3);
        step("sw2_rst",   OP_SW, 1'b1, 1'b1, ZERO, 3'd3);
        check("sw2_rst_state", 32'(state_a), 32'd0);
        check("sw2_rst_ret", ret_a, 32'd0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
